// File: rtl/reg_file_wb_if.sv
// Register file bus: write-back, operand reads, debug read and bring-up status.
interface reg_file_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              WE;
    logic [ADDR_W-1:0] WADDR;
    logic [DATA_W-1:0] DIN;
    logic [ADDR_W-1:0] RADDR_A;
    logic [ADDR_W-1:0] RADDR_B;
    logic [DATA_W-1:0] DOUT_A;
    logic [DATA_W-1:0] DOUT_B;
    logic [ADDR_W-1:0] DBG_ADDR;
    logic [DATA_W-1:0] DBG_OUT;
    logic [CNT_W-1:0]  WR_CNT;
    logic [ADDR_W-1:0] WR_LAST;

    // Datapath side: drives write-back and read addresses, consumes the results.
    modport master (
        output WE, WADDR, DIN, RADDR_A, RADDR_B, DBG_ADDR,
        input  DOUT_A, DOUT_B, DBG_OUT, WR_CNT, WR_LAST
    );

    // Register file side.
    modport slave (
        input  WE, WADDR, DIN, RADDR_A, RADDR_B, DBG_ADDR,
        output DOUT_A, DOUT_B, DBG_OUT, WR_CNT, WR_LAST
    );
endinterface

// File: rtl/reg_file_wb.sv
// 32-entry register file with r0 tied to zero, two combinational operand
// ports with write-through bypass, a registered debug port and a
// committed-write counter for bring-up.
module reg_file_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic          CLK,
    input  logic          RST,
    reg_file_wb_if.slave  bus
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [0:NREGS-1];
    logic [DATA_W-1:0] dbgQ;
    logic [CNT_W-1:0]  wrCnt;
    logic [ADDR_W-1:0] wrLast;
    logic              commit;

    assign commit = bus.WE && (bus.WADDR != '0);

    // Storage: reset clears every entry; r0 is never written so it stays zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[bus.WADDR] <= bus.DIN;
        end
    end

    // Debug port samples the array before this edge's write, so no bypass.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dbgQ <= '0;
        end else if (bus.DBG_ADDR == '0) begin
            dbgQ <= '0;
        end else begin
            dbgQ <= regs[bus.DBG_ADDR];
        end
    end

    // Write-event counter and last-written address, both only on committed writes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wrCnt  <= '0;
            wrLast <= '0;
        end else if (commit) begin
            wrCnt  <= wrCnt + CNT_W'(1);
            wrLast <= bus.WADDR;
        end
    end

    // Operand A: zero for r0, otherwise forward in-flight write-back data.
    always_comb begin
        bus.DOUT_A = regs[bus.RADDR_A];
        if (bus.RADDR_A == '0) begin
            bus.DOUT_A = '0;
        end else if (bus.WE && (bus.WADDR == bus.RADDR_A)) begin
            bus.DOUT_A = bus.DIN;
        end
    end

    // Operand B: same rules as operand A.
    always_comb begin
        bus.DOUT_B = regs[bus.RADDR_B];
        if (bus.RADDR_B == '0) begin
            bus.DOUT_B = '0;
        end else if (bus.WE && (bus.WADDR == bus.RADDR_B)) begin
            bus.DOUT_B = bus.DIN;
        end
    end

    assign bus.DBG_OUT = dbgQ;
    assign bus.WR_CNT  = wrCnt;
    assign bus.WR_LAST = wrLast;
endmodule
